dmem_sched: RTL and testbench
=============================

DMEM_SCHED -- requirements
Module: dmem_sched

Interface
REQ-001 Parameter SB_DEPTH, default 4, store-buffer entries; power of two, at least 2.
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 st_valid  in  1  retired store offered.
REQ-005 st_addr  in  32  store byte address, word-aligned.
REQ-006 st_data  in  32  store data.
REQ-007 st_ready  out  1  buffer can accept a store; equals not sb_full.
REQ-008 ld_valid  in  1  retired load offered.
REQ-009 ld_addr  in  32  load byte address, word-aligned.
REQ-010 ld_ready  out  1  load accepted this cycle.
REQ-011 ld_rsp_valid  out  1  single-cycle load-data pulse.
REQ-012 ld_rsp_data  out  32  load data, valid with ld_rsp_valid.
REQ-013 flush  in  1  mispredict flush; cancels the in-flight load only.
REQ-014 mem_req  out  1  memory request.
REQ-015 mem_we  out  1  1 = write, 0 = read.
REQ-016 mem_addr  out  32  memory address.
REQ-017 mem_wdata  out  32  memory write data.
REQ-018 mem_gnt  in  1  request accepted.
REQ-019 mem_rvalid  in  1  read data valid; at most one per granted read, any later cycle.
REQ-020 mem_rdata  in  32  read data.
REQ-021 sb_empty  out  1  store buffer holds no entries.

Function
REQ-022 Store handshake: st_valid and st_ready in the same cycle pushes {addr, data} at the tail.
REQ-023 States are IDLE, WAIT_GNT and WAIT_RD.
REQ-024 IDLE arbitration, load path: an accepted load without forwarding drives mem_req=1 and mem_we=0 in the same cycle.
REQ-025 IDLE arbitration, store path: otherwise, a non-empty buffer drives mem_req=1 and mem_we=1 with the head entry.
REQ-026 IDLE arbitration, priority: a load has priority unless the buffer is full, in which case the store drains first.
REQ-027 A request without mem_gnt moves to WAIT_GNT; request fields hold stable until granted.
REQ-028 A granted write pops the head, raises no response and returns to IDLE.
REQ-029 A granted read moves to WAIT_RD; mem_rvalid then raises ld_rsp_valid for one cycle with ld_rsp_data = mem_rdata and returns to IDLE.
REQ-030 ld_ready is high only in IDLE, when no address hazard exists and the load path wins arbitration.
REQ-031 Hazard: ld_addr[31:2] equals the address of any valid buffer entry; without forwarding the load waits until those entries drain.
REQ-032 Simultaneous push and pop on a full buffer is legal; occupancy is unchanged.
REQ-033 Pointers wrap modulo SB_DEPTH; occupancy is held in a log2(SB_DEPTH)+1-bit count.
REQ-034 flush in WAIT_RD discards the pending rvalid; the FSM still waits for it, with ld_rsp_valid held 0.
REQ-035 flush in WAIT_GNT for a read keeps the request until granted, then behaves as in REQ-034; the buffer is never flushed.
REQ-036 flush in the same cycle as ld_valid rejects the load (ld_ready=0).

Reset
REQ-037 rst empties the buffer and sets the state to IDLE.
REQ-038 During and after rst: mem_req, mem_we, ld_ready and ld_rsp_valid are 0; sb_empty=1; st_ready=1.
REQ-039 rst mid-transaction abandons it; a later mem_rvalid is ignored.

Configuration
REQ-040 Macro QU_DMEM_STORE_FWD_EN enables store-to-load forwarding.
REQ-041 With the macro defined: a hazard load is accepted in IDLE, returns the youngest matching entry's data one cycle later and issues no memory access.
REQ-042 Without the macro: hazard loads stall per REQ-031.

Structure
REQ-043 qu_common holds the sb_entry_t typedef {addr, data} and the dmem_sched_state_t enum.
REQ-044 One sub-module, store_buf: circular FIFO with a parallel address-match vector and youngest-match data output.

Verification
REQ-045 Three stores (0x100, 0x104, 0x108) with mem_gnt tied 1 -> three writes in order, sb_empty=1 after the third.
REQ-046 Four stores with mem_gnt=0 -> st_ready=0 on the fifth; release gnt -> the head store drains before the pending load at 0x200.
REQ-047 Store 0x40=0xDEAD pending, then load 0x40 -> without the macro, read issues after the write and returns 0xDEAD; with the macro, ld_rsp_data=0xDEAD one cycle after acceptance with no mem_req.
REQ-048 Load 0x80 granted, flush, then mem_rvalid=0x1234 -> no ld_rsp_valid; the FSM returns to IDLE.
REQ-049 Assert rst while in WAIT_GNT with two entries -> mem_req=0 and sb_empty=1 next cycle; a following rvalid is ignored.
REQ-050 Push and pop on a full buffer in the same cycle -> count stays SB_DEPTH and data order is preserved across the wrap.

Source files
------------

// File: rtl/dmem_sched_pkg.sv
// qu_common: shared store-buffer entry and scheduler state types.
package qu_common;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } sb_entry_t;
  typedef enum logic [1:0] {S_IDLE, S_WAIT_GNT, S_WAIT_RD} dmem_sched_state_t;
endpackage

// File: rtl/dmem_sched_if.sv
// dmem_sched_if: core-side load/store handshakes plus the memory port of dmem_sched.
interface dmem_sched_if;
  logic st_valid, st_ready;
  logic [31:0] st_addr, st_data;
  logic ld_valid, ld_ready;
  logic [31:0] ld_addr;
  logic ld_rsp_valid;
  logic [31:0] ld_rsp_data;
  logic flush;
  logic mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic sb_empty;
  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, flush, mem_gnt, mem_rvalid, mem_rdata,
    input st_ready, ld_ready, ld_rsp_valid, ld_rsp_data, mem_req, mem_we, mem_addr, mem_wdata, sb_empty
  );
  modport slave (
    input st_valid, st_addr, st_data, ld_valid, ld_addr, flush, mem_gnt, mem_rvalid, mem_rdata,
    output st_ready, ld_ready, ld_rsp_valid, ld_rsp_data, mem_req, mem_we, mem_addr, mem_wdata, sb_empty
  );
endinterface

// File: rtl/dmem_sched_store_buf.sv
// store_buf: circular store FIFO with a per-entry address match and youngest-match data.
module store_buf
  import qu_common::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  sb_entry_t   wr_entry,
  input  logic [29:0] match_addr,
  output sb_entry_t   head,
  output logic        full,
  output logic        empty,
  output logic        hit,
  output logic [31:0] hit_data
);
  localparam int AW = $clog2(DEPTH);
  sb_entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic [DEPTH-1:0] match_vec;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign head = mem[rd_ptr];
  assign hit = |match_vec;
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) mem[wr_ptr] <= wr_entry;
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // a slot is live when its distance from the head is below the occupancy
  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    logic [AW-1:0] age;
    assign age = AW'(i) - rd_ptr;
    assign match_vec[i] = ({1'b0, age} < count) && mem[i].addr[31:2] == match_addr;
  end
  always_comb begin
    hit_data = '0;
    for (int k = 0; k < DEPTH; k++)
      if (match_vec[rd_ptr + AW'(k)]) hit_data = mem[rd_ptr + AW'(k)].data;
  end
endmodule

// File: rtl/dmem_sched.sv
// dmem_sched: store buffer + single-port memory scheduler for retired loads/stores.
// Define QU_DMEM_STORE_FWD_EN to forward buffered store data to hazard loads.
module dmem_sched
  import qu_common::*;
#(
  parameter int SB_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  dmem_sched_if.slave bus
);
  dmem_sched_state_t state, next;
  sb_entry_t head;
  logic full, empty, hit, idle, ld_ok, ld_go, fwd_go, st_go, req, we, rd_done, killed, rsp_v, we_q;
  logic [31:0] hit_data, addr, wdata, addr_q, wdata_q, rsp_d;
  store_buf #(.DEPTH(SB_DEPTH)) u_sb (
    .clk(clk),
    .rst(rst),
    .push(bus.st_valid && !full && !rst),
    .pop(req && we && bus.mem_gnt),
    .wr_entry('{addr: bus.st_addr, data: bus.st_data}),
    .match_addr(bus.ld_addr[31:2]),
    .head(head),
    .full(full),
    .empty(empty),
    .hit(hit),
    .hit_data(hit_data)
  );
  assign idle = state == S_IDLE;
  assign ld_ok = !rst && idle && bus.ld_valid && !bus.flush && !full;
`ifdef QU_DMEM_STORE_FWD_EN
  assign fwd_go = ld_ok && hit;
`else
  assign fwd_go = 1'b0;
`endif
  assign ld_go = ld_ok && !hit;
  assign st_go = !rst && idle && !empty && !ld_go && !fwd_go;
  assign req = idle ? ld_go || st_go : !rst && state == S_WAIT_GNT;
  assign we = idle ? st_go : !rst && state == S_WAIT_GNT && we_q;
  assign addr = idle ? (ld_go ? bus.ld_addr : head.addr) : addr_q;
  assign wdata = idle ? head.data : wdata_q;
  assign rd_done = state == S_WAIT_RD && bus.mem_rvalid;
  assign bus.mem_req = req;
  assign bus.mem_we = we;
  assign bus.mem_addr = addr;
  assign bus.mem_wdata = wdata;
  assign bus.ld_ready = ld_go || fwd_go;
  assign bus.st_ready = rst || !full;
  assign bus.sb_empty = rst || empty;
  assign bus.ld_rsp_valid = rsp_v;
  assign bus.ld_rsp_data = rsp_d;
  always_comb
    next = idle ? (req ? (bus.mem_gnt ? (we ? S_IDLE : S_WAIT_RD) : S_WAIT_GNT) : S_IDLE)
         : state == S_WAIT_GNT ? (bus.mem_gnt ? (we_q ? S_IDLE : S_WAIT_RD) : S_WAIT_GNT)
         : (bus.mem_rvalid ? S_IDLE : S_WAIT_RD);
  // killed marks an accepted read whose data must be swallowed after a flush
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      killed <= 1'b0;
      rsp_v <= 1'b0;
    end else begin
      state <= next;
      killed <= idle ? 1'b0 : killed || bus.flush;
      rsp_v <= fwd_go || (rd_done && !killed && !bus.flush);
      if (fwd_go || rd_done) rsp_d <= fwd_go ? hit_data : bus.mem_rdata;
      if (idle) {we_q, addr_q, wdata_q} <= {we, addr, wdata};
    end
  end
endmodule

// File: tb/tb_dmem_sched.sv
// tb_dmem_sched: directed scenarios plus a randomized run against a queue/map reference model.
module tb_dmem_sched;
  import qu_common::*;
  logic clk, rst;
  int total, bad;
  dmem_sched_if bus ();
  dmem_sched #(.SB_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  sb_entry_t wq[$];
  logic [31:0] mem_m [logic [31:0]];
  logic [31:0] arch_m [logic [31:0]];
  bit ld_out, ld_kill, rd_out, rsp_due, p_wait, p_we;
  logic [31:0] ld_a, ld_e, rsp_exp, rd_addr, p_addr, p_wdata;
  int n_push, n_wr;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0], 16'h5A5A};
  endfunction
  function automatic logic [31:0] mrd(input logic [31:0] a);
    return mem_m.exists(a) ? mem_m[a] : dflt(a);
  endfunction
  function automatic logic [31:0] ard(input logic [31:0] a);
    return arch_m.exists(a) ? arch_m[a] : dflt(a);
  endfunction
  // memory + program-order model: a load sees every store accepted before it
  task automatic rnd_cycle(input bit quiet);
    bit haz, nxt;
    bus.st_valid = !quiet && $urandom_range(0, 1) == 1;
    bus.st_addr = 32'h40 + ($urandom_range(0, 7) << 2);
    bus.st_data = $urandom;
    bus.ld_valid = !quiet && $urandom_range(0, 2) == 0;
    bus.ld_addr = 32'h40 + ($urandom_range(0, 7) << 2);
    bus.flush = !quiet && $urandom_range(0, 15) == 0;
    bus.mem_gnt = quiet || $urandom_range(0, 1) == 1;
    bus.mem_rvalid = rd_out && (quiet || $urandom_range(0, 2) == 0);
    bus.mem_rdata = bus.mem_rvalid ? mrd(rd_addr) : $urandom;
    #1;
    chk1("st_ready", bus.st_ready, wq.size() < 4);
    chk1("sb_empty", bus.sb_empty, wq.size() == 0);
    chk1("rsp_valid", bus.ld_rsp_valid, rsp_due);
    if (rsp_due) chk("rsp_data", bus.ld_rsp_data, rsp_exp);
    if (p_wait) begin
      chk1("hold_req", bus.mem_req, 1'b1);
      chk1("hold_we", bus.mem_we, p_we);
      chk("hold_addr", bus.mem_addr, p_addr);
      if (p_we) chk("hold_wdata", bus.mem_wdata, p_wdata);
    end
    nxt = 0;
    haz = 0;
    foreach (wq[i]) if (wq[i].addr[31:2] == bus.ld_addr[31:2]) haz = 1;
    if (ld_out || bus.flush) chk1("ld_block", bus.ld_ready, 1'b0);
`ifndef QU_DMEM_STORE_FWD_EN
    if (bus.ld_valid && haz) chk1("haz_stall", bus.ld_ready, 1'b0);
`endif
    if (bus.flush && ld_out) ld_kill = 1;
    if (bus.mem_rvalid) begin
      nxt = !ld_kill;
      rsp_exp = ld_e;
      rd_out = 0;
      ld_out = 0;
    end
    if (bus.ld_valid && bus.ld_ready) begin
`ifdef QU_DMEM_STORE_FWD_EN
      if (haz) begin
        nxt = 1;
        rsp_exp = ard(bus.ld_addr);
      end else
`endif
      begin
        ld_out = 1;
        ld_kill = 0;
        ld_a = bus.ld_addr;
        ld_e = ard(bus.ld_addr);
      end
    end
    if (bus.mem_req && bus.mem_gnt) begin
      if (bus.mem_we) begin
        chk1("wr_pending", wq.size() > 0, 1'b1);
        if (wq.size() > 0) begin
          chk("wr_addr", bus.mem_addr, wq[0].addr);
          chk("wr_data", bus.mem_wdata, wq[0].data);
          mem_m[wq[0].addr] = wq[0].data;
          void'(wq.pop_front());
        end
      end else begin
        chk1("rd_issue", ld_out && !rd_out, 1'b1);
        chk("rd_addr", bus.mem_addr, ld_a);
        rd_out = 1;
        rd_addr = bus.mem_addr;
      end
    end
    p_wait = bus.mem_req && !bus.mem_gnt;
    p_we = bus.mem_we;
    p_addr = bus.mem_addr;
    p_wdata = bus.mem_wdata;
    if (bus.st_valid && bus.st_ready) begin
      wq.push_back('{addr: bus.st_addr, data: bus.st_data});
      arch_m[bus.st_addr] = bus.st_data;
    end
    rsp_due = nxt;
    tick();
  endtask
  initial begin
    total = 0;
    bad = 0;
    rst = 1;
    {bus.st_valid, bus.ld_valid, bus.flush, bus.mem_gnt, bus.mem_rvalid} = '0;
    {bus.st_addr, bus.st_data, bus.ld_addr, bus.mem_rdata} = '0;
    tick();
    tick();
    // reset holds everything quiet even with requests offered
    bus.st_valid = 1; bus.st_addr = 32'h100; bus.ld_valid = 1; bus.ld_addr = 32'h80;
    #1;
    chk1("rst_req", bus.mem_req, 1'b0);
    chk1("rst_we", bus.mem_we, 1'b0);
    chk1("rst_ld_ready", bus.ld_ready, 1'b0);
    chk1("rst_rsp", bus.ld_rsp_valid, 1'b0);
    chk1("rst_empty", bus.sb_empty, 1'b1);
    chk1("rst_st_ready", bus.st_ready, 1'b1);
    tick();
    rst = 0; bus.st_valid = 0; bus.ld_valid = 0;
    #1;
    chk1("post_rst_empty", bus.sb_empty, 1'b1);
    chk1("post_rst_req", bus.mem_req, 1'b0);
    tick();
    // three stores, grant always high
    bus.mem_gnt = 1;
    for (int i = 0; i < 4; i++) begin
      bus.st_valid = i < 3; bus.st_addr = 32'h100 + 4 * i; bus.st_data = 32'hD000 + i;
      #1;
      if (i > 0) begin
        chk1("s3_we", bus.mem_we, 1'b1);
        chk("s3_addr", bus.mem_addr, 32'h100 + 4 * (i - 1));
        chk("s3_data", bus.mem_wdata, 32'hD000 + i - 1);
      end
      tick();
    end
    #1;
    chk1("s3_empty", bus.sb_empty, 1'b1);
    tick();
    // fill with no grant, then a load waits behind the draining head store
    bus.mem_gnt = 0;
    for (int i = 0; i < 4; i++) begin
      bus.st_valid = 1; bus.st_addr = 32'h10 + 4 * i; bus.st_data = 32'hA0 + i;
      #1;
      tick();
    end
    bus.st_addr = 32'h20; bus.ld_valid = 1; bus.ld_addr = 32'h200;
    #1;
    chk1("full_st_ready", bus.st_ready, 1'b0);
    chk1("full_ld_ready", bus.ld_ready, 1'b0);
    chk("full_head", bus.mem_addr, 32'h10);
    tick();
    bus.st_valid = 0; bus.mem_gnt = 1;
    #1;
    chk1("drain_we", bus.mem_we, 1'b1);
    chk("drain_addr", bus.mem_addr, 32'h10);
    chk1("drain_ld_ready", bus.ld_ready, 1'b0);
    tick();
    #1;
    chk1("ld_ready", bus.ld_ready, 1'b1);
    chk1("ld_we", bus.mem_we, 1'b0);
    chk("ld_addr", bus.mem_addr, 32'h200);
    tick();
    bus.ld_valid = 0;
    #1;
    chk1("wait_rd_req", bus.mem_req, 1'b0);
    bus.mem_rvalid = 1; bus.mem_rdata = 32'hCAFE;
    tick();
    bus.mem_rvalid = 0;
    #1;
    chk1("ld_rsp_valid", bus.ld_rsp_valid, 1'b1);
    chk("ld_rsp_data", bus.ld_rsp_data, 32'hCAFE);
    tick(); tick(); tick();
    #1;
    chk1("rest_drained", bus.sb_empty, 1'b1);
    tick();
    // store then load to the same word
    bus.mem_gnt = 0; bus.st_valid = 1; bus.st_addr = 32'h40; bus.st_data = 32'hDEAD;
    #1;
    tick();
    bus.st_valid = 0; bus.ld_valid = 1; bus.ld_addr = 32'h40;
    #1;
`ifdef QU_DMEM_STORE_FWD_EN
    chk1("fwd_ld_ready", bus.ld_ready, 1'b1);
    chk1("fwd_no_req", bus.mem_req, 1'b0);
    tick();
    bus.ld_valid = 0;
    #1;
    chk1("fwd_rsp_valid", bus.ld_rsp_valid, 1'b1);
    chk("fwd_rsp_data", bus.ld_rsp_data, 32'hDEAD);
    bus.mem_gnt = 1;
    tick();
    #1;
    chk1("fwd_drained", bus.sb_empty, 1'b1);
`else
    chk1("haz_ld_ready", bus.ld_ready, 1'b0);
    chk1("haz_we", bus.mem_we, 1'b1);
    chk("haz_addr", bus.mem_addr, 32'h40);
    tick();
    bus.mem_gnt = 1;
    #1;
    chk1("haz_wait", bus.ld_ready, 1'b0);
    tick();
    #1;
    chk1("haz_ld_go", bus.ld_ready, 1'b1);
    chk1("haz_rd_we", bus.mem_we, 1'b0);
    chk("haz_rd_addr", bus.mem_addr, 32'h40);
    tick();
    bus.ld_valid = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'hDEAD;
    #1;
    tick();
    bus.mem_rvalid = 0;
    #1;
    chk1("haz_rsp_valid", bus.ld_rsp_valid, 1'b1);
    chk("haz_rsp_data", bus.ld_rsp_data, 32'hDEAD);
`endif
    tick();
    // flush after grant drops the data
    bus.mem_gnt = 1; bus.ld_valid = 1; bus.ld_addr = 32'h80;
    #1;
    chk1("fl_ld_ready", bus.ld_ready, 1'b1);
    tick();
    bus.ld_valid = 0; bus.flush = 1;
    #1;
    tick();
    bus.flush = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h1234;
    #1;
    tick();
    bus.mem_rvalid = 0;
    #1;
    chk1("fl_no_rsp", bus.ld_rsp_valid, 1'b0);
    tick();
    // flush blocks a same-cycle load; a flushed read still waits for its grant
    bus.ld_valid = 1; bus.ld_addr = 32'h84; bus.flush = 1; bus.mem_gnt = 0;
    #1;
    chk1("fl_same_cycle", bus.ld_ready, 1'b0);
    chk1("fl_same_req", bus.mem_req, 1'b0);
    tick();
    bus.flush = 0;
    #1;
    chk1("fl_idle_again", bus.ld_ready, 1'b1);
    tick();
    bus.ld_valid = 0; bus.flush = 1;
    #1;
    chk1("fl_gnt_req", bus.mem_req, 1'b1);
    chk1("fl_gnt_we", bus.mem_we, 1'b0);
    chk("fl_gnt_addr", bus.mem_addr, 32'h84);
    tick();
    bus.flush = 0; bus.mem_gnt = 1;
    #1;
    chk1("fl_gnt_held", bus.mem_req, 1'b1);
    tick();
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h5555;
    #1;
    tick();
    bus.mem_rvalid = 0;
    #1;
    chk1("fl_gnt_no_rsp", bus.ld_rsp_valid, 1'b0);
    tick();
    // reset while waiting for a grant with two entries buffered
    bus.mem_gnt = 0; bus.st_valid = 1; bus.st_addr = 32'h300;
    #1;
    tick();
    bus.st_addr = 32'h304;
    #1;
    chk1("r_req_pending", bus.mem_req, 1'b1);
    tick();
    bus.st_valid = 0;
    #1;
    chk1("r_two_entries", bus.sb_empty, 1'b0);
    rst = 1;
    #1;
    chk1("r_req_in_rst", bus.mem_req, 1'b0);
    tick();
    rst = 0;
    #1;
    chk1("r_req_after", bus.mem_req, 1'b0);
    chk1("r_empty_after", bus.sb_empty, 1'b1);
    bus.mem_rvalid = 1; bus.mem_rdata = 32'hBAD0;
    tick();
    bus.mem_rvalid = 0;
    #1;
    chk1("r_rvalid_ignored", bus.ld_rsp_valid, 1'b0);
    tick();
    // reset while waiting for read data
    bus.mem_gnt = 1; bus.ld_valid = 1; bus.ld_addr = 32'h90;
    #1;
    tick();
    bus.ld_valid = 0; rst = 1;
    tick();
    rst = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'hBAD1;
    #1;
    tick();
    bus.mem_rvalid = 0;
    #1;
    chk1("r_wait_rd_ignored", bus.ld_rsp_valid, 1'b0);
    tick();
    // full buffer, then push while popping across the pointer wrap
    bus.mem_gnt = 0;
    for (int i = 0; i < 4; i++) begin
      bus.st_valid = 1; bus.st_addr = 32'h500 + 4 * i; bus.st_data = 32'hE0 + i;
      #1;
      tick();
    end
    n_push = 4;
    n_wr = 0;
    bus.mem_gnt = 1;
    for (int c = 0; c < 20 && n_wr < 8; c++) begin
      bus.st_valid = n_push < 8; bus.st_addr = 32'h500 + 4 * n_push; bus.st_data = 32'hE0 + n_push;
      #1;
      if (c == 0) chk1("wrap_full", bus.st_ready, 1'b0);
      if (bus.mem_req && bus.mem_we) begin
        chk("wrap_addr", bus.mem_addr, 32'h500 + 4 * n_wr);
        chk("wrap_data", bus.mem_wdata, 32'hE0 + n_wr);
        n_wr++;
      end
      if (bus.st_valid && bus.st_ready) n_push++;
      tick();
    end
    chk("wrap_writes", 32'(n_wr), 32'd8);
    bus.st_valid = 0;
    // randomized traffic against the reference model
    rst = 1;
    tick();
    tick();
    rst = 0;
    wq.delete();
    mem_m.delete();
    arch_m.delete();
    {ld_out, ld_kill, rd_out, rsp_due, p_wait, p_we} = '0;
    for (int c = 0; c < 3000; c++) rnd_cycle(1'b0);
    for (int c = 0; c < 60; c++) rnd_cycle(1'b1);
    #1;
    chk1("final_empty", bus.sb_empty, 1'b1);
    chk1("final_no_load", ld_out, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
